rf_be_nr1w: RTL and testbench

- Byte-enabled register file: one write port, NRD independent read ports, one-cycle read latency (read address staged).
- Adds a self-clearing init sequencer: after reset, or on a clear request, it writes INIT_VAL to every entry one per cycle, and reports busy.
- Per-port read-valid qualification.
- Used for small architectural and scratch state in the core, where the single-port byte-enable file is too narrow.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_be_nr1w_if.sv | 29 ++
 rtl/rf_init_ctl.sv | 67 ++++++
 rtl/rf_be_nr1w.sv | 115 +++++++++++
 tb/tb_rf_be_nr1w.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the byte-enabled, multi-read-port register file.
package rf_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } init_state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rf_be_nr1w_if.sv
// Write/read/clear bundle of rf_be_nr1w; the client side is master, the file is slave.
interface rf_be_nr1w_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int NRD   = 2
);
  localparam int AW = rf_pkg::addr_w(DEPTH);

  logic                      clear;
  logic                      init_busy;
  logic                      write;
  logic [AW-1:0]             waddr;
  logic [WIDTH/8-1:0]        wben;
  logic [WIDTH-1:0]          din;
  logic [NRD-1:0]            rd_en;
  logic [NRD-1:0][AW-1:0]    raddr;
  logic [NRD-1:0][WIDTH-1:0] dout;
  logic [NRD-1:0]            dout_vld;

  modport master (
    output clear, write, waddr, wben, din, rd_en, raddr,
    input  init_busy, dout, dout_vld
  );

  modport slave (
    input  clear, write, waddr, wben, din, rd_en, raddr,
    output init_busy, dout, dout_vld
  );
endinterface

// File: rtl/rf_init_ctl.sv
// Init sequencer: walks every entry once after reset or clear, owning the write port meanwhile.
module rf_init_ctl import rf_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          eph1,
  input  logic          reset,
  input  logic          clear,
  output logic          init_busy,
  output logic          init_we,
  output logic [AW-1:0] init_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  init_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge eph1) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a clear always restarts the walk from entry 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (clear) begin
          cnt_d = {AW{1'b0}};
        end else if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = {AW{1'b0}};
        end else begin
          cnt_d = cnt_q + AW'(1'b1);
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_INIT;
          cnt_d   = {AW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {AW{1'b0}};
      end
    endcase
  end

  // Outputs; no init write while reset is held so the walk starts cleanly.
  always_comb begin
    init_busy = (state_q == ST_INIT);
    init_we   = (state_q == ST_INIT) && !reset;
    init_addr = cnt_q;
  end

endmodule

// File: rtl/rf_be_nr1w.sv
// Byte-enabled register file: one write port, NRD staged read ports, self-clearing init walk.
module rf_be_nr1w import rf_pkg::*; #(
  parameter int               DEPTH    = 8,
  parameter int               WIDTH    = 32,
  parameter int               NRD      = 2,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic        eph1,
  input  logic        reset,
  rf_be_nr1w_if.slave bus
);

  localparam int               AW   = addr_w(DEPTH);
  localparam int               NB   = WIDTH / 8;
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic          init_busy, init_we;
  logic [AW-1:0] init_addr;

  rf_init_ctl #(.DEPTH(DEPTH), .AW(AW)) u_init_ctl (
    .eph1      (eph1),
    .reset     (reset),
    .clear     (bus.clear),
    .init_busy (init_busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  assign bus.init_busy = init_busy;

  logic [AW-1:0]    wr_addr_s;
  logic [NB-1:0]    wr_ben_s;
  logic [WIDTH-1:0] wr_data_s;

  // Shared write port: the init walk has priority, a same-cycle clear drops the user write.
  always_comb begin
    if (init_we) begin
      wr_addr_s = init_addr;
      wr_ben_s  = {NB{1'b1}};
      wr_data_s = INIT_VAL;
    end else if (bus.write && !bus.clear && !init_busy) begin
      wr_addr_s = bus.waddr;
      wr_ben_s  = bus.wben;
      wr_data_s = bus.din;
    end else begin
      wr_addr_s = {AW{1'b0}};
      wr_ben_s  = {NB{1'b0}};
      wr_data_s = bus.din;
    end
  end

  logic [WIDTH-1:0] mem_word [DEPTH];

  // Out-of-range write addresses match no entry and so write nothing.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    logic [NB-1:0][7:0] ent_q;
    logic [NB-1:0]      ent_we;

    assign ent_we = (wr_addr_s == AW'(e)) ? wr_ben_s : {NB{1'b0}};

    // Per-byte enabled storage flops; contents are established by the init walk.
    always_ff @(posedge eph1) begin
      for (int b = 0; b < NB; b++) begin
        if (ent_we[b]) begin
          ent_q[b] <= wr_data_s[8*b +: 8];
        end
      end
    end

    assign mem_word[e] = ent_q;
  end

  logic [NRD-1:0][AW-1:0]    raddr_q, raddr_d;
  logic [NRD-1:0]            vld_q, vld_d;
  logic [NRD-1:0][WIDTH-1:0] dout_s;

  // Read acceptance: stage the address only for requests taken outside the init walk.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      if (bus.rd_en[p] && !init_busy) begin
        raddr_d[p] = bus.raddr[p];
        vld_d[p]   = 1'b1;
      end else begin
        raddr_d[p] = raddr_q[p];
        vld_d[p]   = 1'b0;
      end
    end
  end

  // Staged read address and valid registers.
  always_ff @(posedge eph1) begin
    if (reset) begin
      raddr_q <= {(NRD*AW){1'b0}};
      vld_q   <= {NRD{1'b0}};
    end else begin
      raddr_q <= raddr_d;
      vld_q   <= vld_d;
    end
  end

  // AND-reduction read mux: no selected entry (invalid or out of range) gives all-ones.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      dout_s[p] = ONES;
      for (int e = 0; e < DEPTH; e++) begin
        dout_s[p] = dout_s[p] &
                    ((vld_q[p] && (raddr_q[p] == AW'(e))) ? mem_word[e] : ONES);
      end
    end
  end

  assign bus.dout     = dout_s;
  assign bus.dout_vld = vld_q;

endmodule

// File: tb/tb_rf_be_nr1w.sv
// Bench for rf_be_nr1w: an 8-entry file (INIT_VAL 0) and a 6-entry file (non-zero INIT_VAL).
module tb_rf_be_nr1w;

  localparam int          W     = 32;
  localparam int          NRD   = 2;
  localparam logic [31:0] ONES  = 32'hFFFF_FFFF;
  localparam logic [31:0] INIT6 = 32'hA5A5_0F0F;

  typedef struct packed {
    logic        wr;
    logic [2:0]  wa;
    logic [3:0]  ben;
    logic [31:0] din;
    logic        clr;
    logic [1:0]  rd;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } cyc_t;

  typedef struct packed {
    logic        d6;
    int          port;
    logic [31:0] data;
    logic        vld;
  } exp_t;

  logic eph1  = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 eph1 = ~eph1;

  rf_be_nr1w_if #(.DEPTH(8), .WIDTH(W), .NRD(NRD)) bus8 ();
  rf_be_nr1w_if #(.DEPTH(6), .WIDTH(W), .NRD(NRD)) bus6 ();

  rf_be_nr1w #(.DEPTH(8), .WIDTH(W), .NRD(NRD), .INIT_VAL(32'h0000_0000)) u_dut8 (
    .eph1(eph1), .reset(reset), .bus(bus8)
  );
  rf_be_nr1w #(.DEPTH(6), .WIDTH(W), .NRD(NRD), .INIT_VAL(INIT6)) u_dut6 (
    .eph1(eph1), .reset(reset), .bus(bus6)
  );

  task automatic tick();
    @(posedge eph1);
    #1;
  endtask

  task automatic idle_all();
    bus8.clear = 1'b0; bus8.write = 1'b0; bus8.waddr = 3'd0; bus8.wben = 4'b0000;
    bus8.din = 32'h0; bus8.rd_en = 2'b00; bus8.raddr[0] = 3'd0; bus8.raddr[1] = 3'd0;
    bus6.clear = 1'b0; bus6.write = 1'b0; bus6.waddr = 3'd0; bus6.wben = 4'b0000;
    bus6.din = 32'h0; bus6.rd_en = 2'b00; bus6.raddr[0] = 3'd0; bus6.raddr[1] = 3'd0;
  endtask

  // Drives one cycle of stimulus and pushes what each port must show after the edge.
  task automatic drive(input logic d6, input cyc_t c, input logic busy_exp);
    logic v0, v1;
    idle_all();
    if (d6) begin
      bus6.write = c.wr; bus6.waddr = c.wa; bus6.wben = c.ben; bus6.din = c.din;
      bus6.clear = c.clr; bus6.rd_en = c.rd; bus6.raddr[0] = c.ra0; bus6.raddr[1] = c.ra1;
    end else begin
      bus8.write = c.wr; bus8.waddr = c.wa; bus8.wben = c.ben; bus8.din = c.din;
      bus8.clear = c.clr; bus8.rd_en = c.rd; bus8.raddr[0] = c.ra0; bus8.raddr[1] = c.ra1;
    end
    v0 = c.rd[0] && !busy_exp;
    v1 = c.rd[1] && !busy_exp;
    sb.push_back('{d6, 0, v0 ? c.e0 : ONES, v0});
    sb.push_back('{d6, 1, v1 ? c.e1 : ONES, v1});
  endtask

  task automatic test_reset();
    int busy;
    idle_all();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus8.init_busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_busy: init_busy=%b, expected 1", bus8.init_busy);
    end
    for (int p = 0; p < NRD; p++) begin
      n_cmp++;
      if (bus8.dout_vld[p] !== 1'b0 || bus8.dout[p] !== ONES) begin
        n_err++;
        $display("FAIL reset_dout port%0d: dout=%h vld=%b, expected %h vld=0",
                 p, bus8.dout[p], bus8.dout_vld[p], ONES);
      end
    end
    reset = 1'b0;
    busy = 0;
    while (bus8.init_busy === 1'b1 && busy < 20) begin
      tick();
      busy++;
    end
    n_cmp++;
    if (busy !== 8) begin
      n_err++;
      $display("FAIL init_len: busy for %0d cycles, expected 8", busy);
    end
    n_cmp++;
    if (bus6.init_busy !== 1'b0) begin
      n_err++;
      $display("FAIL init6_done: init_busy=%b, expected 0", bus6.init_busy);
    end
  endtask

  task automatic test_init_read();
    cyc_t c;
    exp_t e;
    logic [31:0] got;
    logic gv;
    for (int a = 0; a <= 8; a++) begin
      c = '0;
      if (a < 8) begin
        c.rd  = 2'b11;
        c.ra0 = 3'(a);
        c.ra1 = 3'(7 - a);
      end
      drive(1'b0, c, 1'b0);
      tick();
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = e.d6 ? bus6.dout[e.port] : bus8.dout[e.port];
        gv  = e.d6 ? bus6.dout_vld[e.port] : bus8.dout_vld[e.port];
        n_cmp++;
        if (got !== e.data || gv !== e.vld) begin
          n_err++;
          $display("FAIL init_read step%0d port%0d: dout=%h vld=%b, expected %h vld=%b",
                   a, e.port, got, gv, e.data, e.vld);
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    cyc_t tbl [5];
    exp_t e;
    logic [31:0] got;
    logic gv;
    tbl = '{
      '{1'b1, 3'd3, 4'b0101, 32'hAABB_CCDD, 1'b0, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0},
      '{1'b0, 3'd0, 4'b0000, 32'h0, 1'b0, 2'b01, 3'd3, 3'd0, 32'h00BB_00DD, 32'h0},
      '{1'b1, 3'd6, 4'b0101, 32'hAABB_CCDD, 1'b0, 2'b11, 3'd6, 3'd6, 32'h00BB_00DD, 32'h00BB_00DD},
      '{1'b1, 3'd3, 4'b1010, 32'h1122_3344, 1'b0, 2'b11, 3'd6, 3'd3, 32'h00BB_00DD, 32'h11BB_33DD},
      '{1'b1, 3'd3, 4'b0000, 32'hFFFF_FFFF, 1'b0, 2'b10, 3'd0, 3'd3, 32'h0, 32'h11BB_33DD}
    };
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, tbl[i], 1'b0);
      tick();
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = e.d6 ? bus6.dout[e.port] : bus8.dout[e.port];
        gv  = e.d6 ? bus6.dout_vld[e.port] : bus8.dout_vld[e.port];
        n_cmp++;
        if (got !== e.data || gv !== e.vld) begin
          n_err++;
          $display("FAIL byte_enable step%0d port%0d: dout=%h vld=%b, expected %h vld=%b",
                   i, e.port, got, gv, e.data, e.vld);
        end
      end
    end
  endtask

  task automatic test_multi_port();
    cyc_t tbl [5];
    exp_t e;
    logic [31:0] got;
    logic gv;
    tbl = '{
      '{1'b1, 3'd2, 4'b1111, 32'h1111_1111, 1'b0, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0},
      '{1'b1, 3'd5, 4'b1111, 32'h5555_5555, 1'b0, 2'b01, 3'd2, 3'd0, 32'h1111_1111, 32'h0},
      '{1'b0, 3'd0, 4'b0000, 32'h0, 1'b0, 2'b11, 3'd2, 3'd5, 32'h1111_1111, 32'h5555_5555},
      '{1'b0, 3'd0, 4'b0000, 32'h0, 1'b0, 2'b11, 3'd5, 3'd5, 32'h5555_5555, 32'h5555_5555},
      '{1'b0, 3'd0, 4'b0000, 32'h0, 1'b0, 2'b10, 3'd0, 3'd2, 32'h0, 32'h1111_1111}
    };
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, tbl[i], 1'b0);
      tick();
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = e.d6 ? bus6.dout[e.port] : bus8.dout[e.port];
        gv  = e.d6 ? bus6.dout_vld[e.port] : bus8.dout_vld[e.port];
        n_cmp++;
        if (got !== e.data || gv !== e.vld) begin
          n_err++;
          $display("FAIL multi_port step%0d port%0d: dout=%h vld=%b, expected %h vld=%b",
                   i, e.port, got, gv, e.data, e.vld);
        end
      end
    end
  endtask

  task automatic test_clear();
    cyc_t tbl [6];
    exp_t e;
    logic [31:0] got;
    logic gv;
    int busy;
    // 0-1: set up then clear with a colliding write; 2: traffic during INIT; 3-5: after INIT.
    tbl = '{
      '{1'b1, 3'd1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 2'b00, 3'd0, 3'd0, 32'h0, 32'h0},
      '{1'b1, 3'd4, 4'b1111, 32'h1234_5678, 1'b1, 2'b01, 3'd1, 3'd0, 32'hDEAD_BEEF, 32'h0},
      '{1'b1, 3'd2, 4'b1111, 32'h7777_7777, 1'b0, 2'b11, 3'd1, 3'd4, 32'h0, 32'h0},
      '{1'b0, 3'd0, 4'b0000, 32'h0, 1'b0, 2'b11, 3'd1, 3'd4, 32'h0, 32'h0},
      '{1'b0, 3'd0, 4'b0000, 32'h0, 1'b0, 2'b11, 3'd2, 3'd5, 32'h0, 32'h0},
      '{1'b0, 3'd0, 4'b0000, 32'h0, 1'b0, 2'b01, 3'd3, 3'd0, 32'h0, 32'h0}
    };
    busy = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        while (bus8.init_busy === 1'b1 && busy < 20) begin
          drive(1'b0, tbl[2], 1'b1);
          tick();
          busy++;
          while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = bus8.dout[e.port];
            gv  = bus8.dout_vld[e.port];
            n_cmp++;
            if (got !== e.data || gv !== e.vld) begin
              n_err++;
              $display("FAIL clear_busy_read cycle%0d port%0d: dout=%h vld=%b, expected %h vld=%b",
                       busy, e.port, got, gv, e.data, e.vld);
            end
          end
        end
        n_cmp++;
        if (busy !== 8) begin
          n_err++;
          $display("FAIL clear_len: busy for %0d cycles, expected 8", busy);
        end
      end else begin
        drive(1'b0, tbl[i], 1'b0);
        tick();
        while (sb.size() > 0) begin
          e   = sb.pop_front();
          got = bus8.dout[e.port];
          gv  = bus8.dout_vld[e.port];
          n_cmp++;
          if (got !== e.data || gv !== e.vld) begin
            n_err++;
            $display("FAIL clear step%0d port%0d: dout=%h vld=%b, expected %h vld=%b",
                     i, e.port, got, gv, e.data, e.vld);
          end
        end
      end
    end
  endtask

  task automatic test_mid_init();
    int busy;
    // Clear again once the walk has reached entry 5.
    idle_all();
    bus8.clear = 1'b1;
    tick();
    idle_all();
    repeat (5) tick();
    n_cmp++;
    if (bus8.init_busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_clear_pre: init_busy=%b, expected 1", bus8.init_busy);
    end
    bus8.clear = 1'b1;
    tick();
    idle_all();
    busy = 0;
    while (bus8.init_busy === 1'b1 && busy < 20) begin
      tick();
      busy++;
    end
    n_cmp++;
    if (busy !== 8) begin
      n_err++;
      $display("FAIL mid_clear_len: busy for %0d cycles, expected 8", busy);
    end
    // Reset once the walk has reached entry 3.
    bus8.clear = 1'b1;
    tick();
    idle_all();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    busy = 0;
    while (bus8.init_busy === 1'b1 && busy < 20) begin
      tick();
      busy++;
    end
    n_cmp++;
    if (busy !== 8) begin
      n_err++;
      $display("FAIL mid_reset_len: busy for %0d cycles, expected 8", busy);
    end
  endtask

  task automatic test_out_of_range();
    cyc_t tbl [7];
    exp_t e;
    logic [31:0] got;
    logic gv;
    tbl = '{
      '{1'b0, 3'd0, 4'b0000, 32'h0, 1'b0, 2'b11, 3'd0, 3'd5, INIT6, INIT6},
      '{1'b1, 3'd7, 4'b1111, 32'hCAFE_F00D, 1'b0, 2'b01, 3'd7, 3'd0, ONES, 32'h0},
      '{1'b1, 3'd2, 4'b0011, 32'h0000_1234, 1'b0, 2'b10, 3'd0, 3'd7, 32'h0, ONES},
      '{1'b1, 3'd6, 4'b1111, 32'h0000_0000, 1'b0, 2'b11, 3'd2, 3'd6, 32'hA5A5_1234, ONES},
      '{1'b0, 3'd0, 4'b0000, 32'h0, 1'b0, 2'b11, 3'd0, 3'd1, INIT6, INIT6},
      '{1'b0, 3'd0, 4'b0000, 32'h0, 1'b0, 2'b11, 3'd3, 3'd4, INIT6, INIT6},
      '{1'b0, 3'd0, 4'b0000, 32'h0, 1'b0, 2'b11, 3'd5, 3'd7, INIT6, ONES}
    };
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, tbl[i], 1'b0);
      tick();
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = e.d6 ? bus6.dout[e.port] : bus8.dout[e.port];
        gv  = e.d6 ? bus6.dout_vld[e.port] : bus8.dout_vld[e.port];
        n_cmp++;
        if (got !== e.data || gv !== e.vld) begin
          n_err++;
          $display("FAIL out_of_range step%0d port%0d: dout=%h vld=%b, expected %h vld=%b",
                   i, e.port, got, gv, e.data, e.vld);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    test_reset();
    test_init_read();
    test_byte_enable();
    test_multi_port();
    test_clear();
    test_mid_init();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
